// File: rtl/player_engine_multi.sv
// Purpose : player controller for the lane-crossing game (grid moves, car collision, lives, BCD score, 7-seg).
// Latency : car overlap -> hit_pulse 2 cycles; player_y==0 -> score_pulse/respawn 1 cycle; BCD -> 7-seg 1 cycle.
// Backpres: none; switches and cars are level-sampled every cycle, every output is a registered level or strobe.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   SW1..SW4            up/down/left/right requests (already synchronised)
//   car_x/car_y/car_en  packed per-car position (10 bits each) and collision enable
//   player_x/player_y   player top-left corner, px
//   lives               thermometer life count, LSB-aligned
//   tens/units          BCD score; seg_tens/seg_units are their active-low ABCDEFG patterns
//   hit_pulse           one-cycle strobe on life loss
//   score_pulse         one-cycle strobe on a completed crossing
//   game_over           high while the game is over
module player_engine_multi #(
    parameter int NUM_CARS      = 8,
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int PLAYER_W      = 32,
    parameter int PLAYER_H      = 32,
    parameter int CAR_W         = 64,
    parameter int CAR_H         = 32,
    parameter int STEP          = 32,
    parameter int MOVE_PERIOD   = 5000000,
    parameter int LIVES         = 4,
    parameter int INVULN_CYCLES = 25000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SW1,
    input  logic                    SW2,
    input  logic                    SW3,
    input  logic                    SW4,
    input  logic [10*NUM_CARS-1:0]  car_x,
    input  logic [10*NUM_CARS-1:0]  car_y,
    input  logic [NUM_CARS-1:0]     car_en,
    output logic [9:0]              player_x,
    output logic [9:0]              player_y,
    output logic [LIVES-1:0]        lives,
    output logic [3:0]              tens,
    output logic [3:0]              units,
    output logic [6:0]              seg_tens,
    output logic [6:0]              seg_units,
    output logic                    hit_pulse,
    output logic                    score_pulse,
    output logic                    game_over
);

    localparam logic [1:0] ST_PLAY   = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_OVER   = 2'd2;

    localparam int MCNT_W = $clog2(MOVE_PERIOD);
    localparam int ICNT_W = $clog2(INVULN_CYCLES + 1);

    localparam logic [MCNT_W-1:0] MOVE_LAST = MCNT_W'(MOVE_PERIOD - 1);
    localparam logic [ICNT_W-1:0] INV_LAST  = ICNT_W'(INVULN_CYCLES - 1);

    localparam logic [9:0]  X_HOME  = 10'(H_DISPLAY / 2);
    localparam logic [9:0]  Y_HOME  = 10'(V_DISPLAY - PLAYER_H);
    localparam logic [10:0] X_MAX   = 11'(H_DISPLAY - PLAYER_W);
    localparam logic [10:0] Y_MAX   = 11'(V_DISPLAY - PLAYER_H);
    localparam logic [10:0] STEP_11 = 11'(STEP);
    localparam logic [9:0]  STEP_10 = 10'(STEP);
    localparam logic [10:0] PW_11   = 11'(PLAYER_W);
    localparam logic [10:0] PH_11   = 11'(PLAYER_H);
    localparam logic [10:0] CW_11   = 11'(CAR_W);
    localparam logic [10:0] CH_11   = 11'(CAR_H);

    localparam logic [6:0] SEG_ZERO = 7'b0000001;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [1:0]          state;
    logic [MCNT_W-1:0]   move_cnt;
    logic [ICNT_W-1:0]   inv_cnt;
    logic                hit_q;
    logic                move_wrap;
    logic                restart;
    logic [10:0]         px_11;
    logic [10:0]         py_11;
    logic [NUM_CARS-1:0] car_hit;
    logic [9:0]          mv_x;
    logic [9:0]          mv_y;

    // Holding all four switches is a player-initiated reset.
    assign restart   = RST | (SW1 & SW2 & SW3 & SW4);
    assign move_wrap = (move_cnt == MOVE_LAST);

    // Geometry runs at 11 bits so x+width never wraps past 1023.
    assign px_11 = {1'b0, player_x};
    assign py_11 = {1'b0, player_y};

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        logic [10:0] cx;
        logic [10:0] cy;
        assign cx = {1'b0, car_x[10*i +: 10]};
        assign cy = {1'b0, car_y[10*i +: 10]};
        assign car_hit[i] = car_en[i]
                          && (px_11 + PW_11 > cx) && (px_11 < cx + CW_11)
                          && (py_11 + PH_11 > cy) && (py_11 < cy + CH_11);
    end

    // Highest-priority pressed switch picks the direction; if that direction
    // is blocked by the screen edge the player stays put rather than trying
    // a lower-priority switch.
    always_comb begin
        mv_x = player_x;
        mv_y = player_y;
        if (SW1) begin
            if (py_11 >= STEP_11) mv_y = player_y - STEP_10;
        end else if (SW2) begin
            if (py_11 + STEP_11 <= Y_MAX) mv_y = player_y + STEP_10;
        end else if (SW3) begin
            if (px_11 >= STEP_11) mv_x = player_x - STEP_10;
        end else if (SW4) begin
            if (px_11 + STEP_11 <= X_MAX) mv_x = player_x + STEP_10;
        end
    end

    always_ff @(posedge CLK) begin
        if (restart) begin
            state       <= ST_PLAY;
            move_cnt    <= '0;
            inv_cnt     <= '0;
            hit_q       <= 1'b0;
            player_x    <= X_HOME;
            player_y    <= Y_HOME;
            lives       <= '1;
            tens        <= 4'd0;
            units       <= 4'd0;
            seg_tens    <= SEG_ZERO;
            seg_units   <= SEG_ZERO;
            hit_pulse   <= 1'b0;
            score_pulse <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            score_pulse <= 1'b0;
            hit_q       <= |car_hit;
            seg_tens    <= seg7(tens);
            seg_units   <= seg7(units);
            move_cnt    <= move_wrap ? '0 : move_cnt + MCNT_W'(1);

            if (state == ST_PLAY && hit_q) begin
                // A hit outranks both a crossing and a move in the same cycle.
                hit_pulse <= 1'b1;
                player_x  <= X_HOME;
                player_y  <= Y_HOME;
                lives     <= lives >> 1;
                if ((lives >> 1) == '0) begin
                    state     <= ST_OVER;
                    game_over <= 1'b1;
                end else begin
                    state   <= ST_INVULN;
                    inv_cnt <= '0;
                end
            end else if (state != ST_OVER) begin
                if (state == ST_INVULN) begin
                    if (inv_cnt == INV_LAST) state <= ST_PLAY;
                    else                     inv_cnt <= inv_cnt + ICNT_W'(1);
                end
                if (player_y == 10'd0) begin
                    score_pulse <= 1'b1;
                    player_x    <= X_HOME;
                    player_y    <= Y_HOME;
                    // Score sticks at 99 but the strobe still fires.
                    if (!(tens == 4'd9 && units == 4'd9)) begin
                        if (units == 4'd9) begin
                            units <= 4'd0;
                            tens  <= tens + 4'd1;
                        end else begin
                            units <= units + 4'd1;
                        end
                    end
                end else if (move_wrap) begin
                    player_x <= mv_x;
                    player_y <= mv_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_engine_multi.sv
// Purpose : directed + random bench for player_engine_multi against a behavioural game model.
// Latency : compares every output one time unit after each rising clock edge.
// Backpres: none; stimulus is driven freely each cycle.
module tb_player_engine_multi;

    localparam int NC   = 4;
    localparam int MP   = 4;
    localparam int LV   = 4;
    localparam int IC   = 8;
    localparam int STEP = 32;
    localparam int HOME_X = 320;
    localparam int HOME_Y = 448;

    logic            CLK = 1'b0;
    logic            RST;
    logic            SW1, SW2, SW3, SW4;
    logic [10*NC-1:0] car_x, car_y;
    logic [NC-1:0]    car_en;
    logic [9:0]       player_x, player_y;
    logic [LV-1:0]    lives;
    logic [3:0]       tens, units;
    logic [6:0]       seg_tens, seg_units;
    logic             hit_pulse, score_pulse, game_over;

    player_engine_multi #(
        .NUM_CARS(NC), .H_DISPLAY(640), .V_DISPLAY(480),
        .PLAYER_W(32), .PLAYER_H(32), .CAR_W(64), .CAR_H(32),
        .STEP(STEP), .MOVE_PERIOD(MP), .LIVES(LV), .INVULN_CYCLES(IC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
        .car_x(car_x), .car_y(car_y), .car_en(car_en),
        .player_x(player_x), .player_y(player_y), .lives(lives),
        .tens(tens), .units(units), .seg_tens(seg_tens), .seg_units(seg_units),
        .hit_pulse(hit_pulse), .score_pulse(score_pulse), .game_over(game_over)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] segtab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Behavioural model: plain integers for position, life count and decimal score.
    typedef enum {M_PLAY, M_INVULN, M_OVER} mode_t;
    mode_t m_mode;
    int    m_px, m_py, m_lives, m_score, m_shown, m_mtick, m_inv_left;
    bit    m_seen_hit, m_hp, m_sp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_PLAY; m_px = HOME_X; m_py = HOME_Y; m_lives = LV;
        m_score = 0; m_shown = 0; m_mtick = 0; m_inv_left = 0;
        m_seen_hit = 0; m_hp = 0; m_sp = 0;
    endtask

    task automatic model_step();
        bit overlap, moving, hit_now;
        overlap = 0;
        for (int i = 0; i < NC; i++) begin
            int cx, cy;
            cx = int'(car_x[10*i +: 10]);
            cy = int'(car_y[10*i +: 10]);
            if (car_en[i] && m_px + 32 > cx && m_px < cx + 64 && m_py + 32 > cy && m_py < cy + 32)
                overlap = 1;
        end
        if (RST || (SW1 && SW2 && SW3 && SW4)) begin
            model_reset();
            return;
        end
        m_shown = m_score;
        m_hp = 0;
        m_sp = 0;
        m_mtick++;
        moving = (m_mtick == MP);
        if (moving) m_mtick = 0;
        hit_now = m_seen_hit;
        m_seen_hit = overlap;
        if (m_mode == M_PLAY && hit_now) begin
            m_lives--; m_hp = 1; m_px = HOME_X; m_py = HOME_Y;
            if (m_lives == 0) m_mode = M_OVER;
            else begin m_mode = M_INVULN; m_inv_left = IC; end
        end else if (m_mode != M_OVER) begin
            if (m_mode == M_INVULN) begin
                m_inv_left--;
                if (m_inv_left == 0) m_mode = M_PLAY;
            end
            if (m_py == 0) begin
                if (m_score < 99) m_score++;
                m_sp = 1; m_px = HOME_X; m_py = HOME_Y;
            end else if (moving) begin
                if (SW1)      begin if (m_py >= STEP) m_py -= STEP; end
                else if (SW2) begin if (m_py + STEP <= 448) m_py += STEP; end
                else if (SW3) begin if (m_px >= STEP) m_px -= STEP; end
                else if (SW4) begin if (m_px + STEP <= 608) m_px += STEP; end
            end
        end
    endtask

    task automatic cycle();
        logic [48:0] obs, exp;
        model_step();
        @(posedge CLK);
        #1;
        obs = {player_x, player_y, lives, tens, units, seg_tens, seg_units, hit_pulse, score_pulse, game_over};
        exp = {10'(m_px), 10'(m_py), 4'((1 << m_lives) - 1), 4'(m_score / 10), 4'(m_score % 10),
               segtab[m_shown / 10], segtab[m_shown % 10], m_hp, m_sp, (m_mode == M_OVER)};
        check("cycle_outputs", 64'(obs), 64'(exp));
    endtask

    task automatic wait_score(input string tag, input int budget);
        int n;
        n = 0;
        do begin cycle(); n++; end while (score_pulse !== 1'b1 && n < budget);
        check(tag, 64'(score_pulse), 64'd1);
    endtask

    initial begin
        int hits, n;
        bit any_hit;
        RST = 1'b1; SW1 = 0; SW2 = 0; SW3 = 0; SW4 = 0;
        car_x = '0; car_y = '0; car_en = '0;
        model_reset();

        // Reset values
        cycle();
        check("rst_x", 64'(player_x), 64'd320);
        check("rst_y", 64'(player_y), 64'd448);
        check("rst_lives", 64'(lives), 64'b1111);
        check("rst_score", 64'({tens, units}), 64'h00);
        check("rst_seg", 64'({seg_tens, seg_units}), 64'({7'b0000001, 7'b0000001}));
        check("rst_strobes", 64'({hit_pulse, score_pulse, game_over}), 64'd0);
        RST = 1'b0;

        // Climb to the top with SW1 and score one crossing
        SW1 = 1'b1;
        wait_score("first_cross_seen", 100);
        check("cross_respawn_y", 64'(player_y), 64'd448);
        check("cross_units", 64'(units), 64'd1);
        SW1 = 1'b0;
        cycle();
        check("seg_units_one", 64'(seg_units), 64'(7'b1001111));

        // Car parked on the player: hit two cycles later, then invulnerable
        car_x[9:0] = 10'd320; car_y[9:0] = 10'd448; car_en = 4'b0001;
        cycle();
        check("hit_not_yet", 64'(hit_pulse), 64'd0);
        cycle();
        check("hit_pulse", 64'(hit_pulse), 64'd1);
        check("hit_lives", 64'(lives), 64'b0111);
        for (int k = 0; k < IC; k++) begin
            cycle();
            check("invuln_lives", 64'(lives), 64'b0111);
            check("invuln_nohit", 64'(hit_pulse), 64'd0);
        end
        hits = 0; n = 0;
        while (game_over !== 1'b1 && n < 100) begin
            cycle();
            if (hit_pulse === 1'b1) hits++;
            n++;
        end
        check("game_over_reached", 64'(game_over), 64'd1);
        check("remaining_hits", 64'(hits), 64'd3);
        check("over_lives", 64'(lives), 64'd0);

        // Frozen while over; all switches restart
        car_en = '0; SW1 = 1'b1;
        repeat (10) cycle();
        check("over_frozen_y", 64'(player_y), 64'd448);
        SW2 = 1'b1; SW3 = 1'b1; SW4 = 1'b1;
        cycle();
        check("restart_go", 64'(game_over), 64'd0);
        check("restart_lives", 64'(lives), 64'b1111);
        check("restart_score", 64'({tens, units}), 64'h00);
        check("restart_pos", 64'({player_x, player_y}), 64'({10'd320, 10'd448}));
        SW1 = 0; SW2 = 0; SW3 = 0; SW4 = 0;
        cycle();

        // Drive the score to 99 and once more to show saturation
        SW1 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            wait_score("sat_cross_seen", 100);
            if (k == 99) check("score_99", 64'({tens, units}), 64'h99);
        end
        check("sat_score", 64'({tens, units}), 64'h99);
        check("sat_pulse", 64'(score_pulse), 64'd1);
        SW1 = 1'b0;
        cycle();
        check("sat_seg", 64'({seg_tens, seg_units}), 64'({7'b0000100, 7'b0000100}));

        // Left edge block with right also pressed; disabled overlapping car
        RST = 1'b1; cycle(); RST = 1'b0;
        car_x = {10'd600, 10'd600, 10'd600, 10'd0};
        car_y = {10'd0, 10'd0, 10'd0, 10'd448};
        car_en = 4'b1110;
        SW3 = 1'b1;
        any_hit = 0; n = 0;
        do begin cycle(); n++; if (hit_pulse === 1'b1) any_hit = 1; end
        while (player_x !== 10'd0 && n < 100);
        check("left_reached", 64'(player_x), 64'd0);
        SW4 = 1'b1;
        repeat (12) begin cycle(); if (hit_pulse === 1'b1) any_hit = 1; end
        check("left_blocked_x", 64'(player_x), 64'd0);
        check("disabled_car_nohit", 64'(any_hit), 64'd0);
        check("disabled_car_lives", 64'(lives), 64'b1111);
        SW3 = 1'b0; SW4 = 1'b0;

        // Random play against the model
        for (int t = 0; t < 3000; t++) begin
            RST = ($urandom_range(0, 299) == 0);
            SW1 = ($urandom_range(0, 2) == 0);
            SW2 = ($urandom_range(0, 3) == 0);
            SW3 = ($urandom_range(0, 3) == 0);
            SW4 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NC; i++) begin
                    car_x[10*i +: 10] = 10'($urandom_range(0, 639));
                    car_y[10*i +: 10] = 10'(32 * $urandom_range(0, 14));
                end
                car_en = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
